serial_link_credit_return: RTL

//  Receiver-side end of the link's credit-based flow control. Tracks receive-buffer

---
 rtl/serial_link_credit_return.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/serial_link_credit_return.sv
// serial_link_credit_return
//
// Receiver-side end of the link's credit-based flow control. It sits between
// the receive FIFO and the link TX arbiter. It tracks how many receive-buffer
// slots are occupied and how many credits are owed back to the peer sender.
// Owed credits ride on outgoing data packets. A credit-only packet is requested
// in two cases: outgoing traffic has been absent for too long, or too many
// credits have piled up.
//
// Ports:
//   clk_i                clock
//   rst_i                asynchronous reset, active-high
//   rx_push_i            peer packet written into the receive buffer
//   consume_i            receive-buffer slot freed; one credit now owed
//   tx_valid_i           local data packet offered to link TX
//   tx_ready_i           link TX accepts the data packet
//   credits_o            credits carried by a data or credit-only packet at handshake
//   credit_only_valid_o  request to send a credit-only packet
//   credit_only_ready_i  TX accepts the credit-only packet
//   occupancy_o          occupied receive-buffer slots
//   err_overflow_o       sticky: push while full, or owed credits exceeded NumCredits
//   err_underflow_o      sticky: consume while empty

module serial_link_credit_return #(
    parameter int NumCredits    = 10,
    parameter int ForceThresh   = NumCredits - 2,
    parameter int CreditTimeout = 16,
    localparam int CreditW      = $clog2(NumCredits + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               rx_push_i,
    input  logic               consume_i,
    input  logic               tx_valid_i,
    input  logic               tx_ready_i,
    output logic [CreditW-1:0] credits_o,
    output logic               credit_only_valid_o,
    input  logic               credit_only_ready_i,
    output logic [CreditW-1:0] occupancy_o,
    output logic               err_overflow_o,
    output logic               err_underflow_o
);

    localparam int TimerW = (CreditTimeout > 1) ? $clog2(CreditTimeout) : 1;

    localparam logic [CreditW-1:0] MaxCount    = CreditW'(NumCredits);
    localparam logic [CreditW-1:0] ThreshVal   = CreditW'(ForceThresh);
    localparam logic [TimerW-1:0]  TimeoutLast = TimerW'(CreditTimeout - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_REQ
    } state_t;

    state_t              state_q, state_d;
    logic [CreditW-1:0]  pending_q, pending_d;
    logic [CreditW-1:0]  occupancy_q, occupancy_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic                err_ovf_q, err_unf_q;

    logic                data_hs;
    logic                co_hs;
    logic                send;
    logic                push_ok;
    logic                consume_ok;
    logic                push_at_full;
    logic                consume_at_empty;
    logic                pending_ovf;
    logic [CreditW:0]    pending_sum;

    // Handshake decode plus the pending/occupancy next-state arithmetic.
    // The credit request is a Moore output of the state register, so neither
    // ready input can reach credit_only_valid_o combinationally.
    // A consume that lands on a send cycle starts the next packet's count
    // rather than being lost. Illegal pushes and consumes are dropped here so
    // the counters never wrap.
    always_comb begin
        data_hs          = tx_valid_i & tx_ready_i;
        co_hs            = (state_q == ST_REQ) & credit_only_ready_i;
        send             = data_hs | co_hs;
        push_at_full     = rx_push_i & (occupancy_q == MaxCount);
        consume_at_empty = consume_i & (occupancy_q == '0);
        push_ok          = rx_push_i & ~push_at_full;
        consume_ok       = consume_i & ~consume_at_empty;

        pending_sum = {1'b0, (send ? '0 : pending_q)} + (CreditW + 1)'(consume_ok);
        pending_ovf = 1'b0;
        pending_d   = pending_sum[CreditW-1:0];
        if (pending_sum > {1'b0, MaxCount}) begin
            pending_d   = MaxCount;
            pending_ovf = 1'b1;
        end

        occupancy_d = occupancy_q + CreditW'(push_ok) - CreditW'(consume_ok);
    end

    // Credit-only request FSM. Wait counts idle cycles while credits are owed.
    // A data handshake restarts the count because it already carried the
    // credits. Req holds the request until it is accepted. A data handshake
    // in Req also retires the request, since the credits went with the data.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        unique case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (pending_d != '0) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (data_hs) begin
                    timer_d = '0;
                    if (!consume_ok) begin
                        state_d = ST_IDLE;
                    end
                end else if ((timer_q == TimeoutLast) || (pending_q >= ThreshVal)) begin
                    state_d = ST_REQ;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            ST_REQ: begin
                timer_d = '0;
                if (send) begin
                    state_d = consume_ok ? ST_WAIT : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // State and counter registers. Reset drops any outstanding request. The
    // peer re-trains the link and restores its own credit count afterwards.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            occupancy_q <= '0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            occupancy_q <= occupancy_d;
            timer_q     <= timer_d;
        end
    end

    // Sticky error flags. Only reset clears them.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            if (push_at_full || pending_ovf) begin
                err_ovf_q <= 1'b1;
            end
            if (consume_at_empty) begin
                err_unf_q <= 1'b1;
            end
        end
    end

    assign credits_o           = pending_q;
    assign credit_only_valid_o = (state_q == ST_REQ);
    assign occupancy_o         = occupancy_q;
    assign err_overflow_o      = err_ovf_q;
    assign err_underflow_o     = err_unf_q;

endmodule
